sync_fifo_flags: RTL

Single-clock, parametrised FIFO for the TT tile datapath. It replaces the fixed 4-bit, 8-deep buffer. It adds:
- an occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags with a clear input
- a synchronous flush
- registered read data with a valid strobe

It sits between the ui_in capture logic and the uo_out register stage.

---
 rtl/sync_fifo_flags_if.sv | 32 +++
 rtl/sync_fifo_flags.sv | 90 +++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - write/read handshake, status and error bundle for sync_fifo_flags
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output flush, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold flags, sticky errors and flush
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input logic              clk,
  input logic              rst_n,
  sync_fifo_flags_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wa, ra;

  // Flags decode the registered count only, so request inputs never reach them.
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign wa    = bus.wr_en & ~full & ~bus.flush;
  assign ra    = bus.rd_en & ~empty & ~bus.flush;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = ra;
    overflow_d  = (overflow_q & ~bus.clr_err) | (bus.wr_en & full & ~bus.flush);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd_en & empty & ~bus.flush);
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wa) wptr_d = wptr_q + 1'b1;
      if (ra) begin
        rptr_d    = rptr_q + 1'b1;
        rd_data_d = mem_q[rptr_q];
      end
      if (wa && !ra)      count_d = count_q + 1'b1;
      else if (ra && !wa) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; its contents are only observable through accepted reads.
  always_ff @(posedge clk) begin
    if (wa) mem_q[wptr_q] <= bus.wr_data;
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
